// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared hazard codes and sequencer state encoding for the RV32 pipeline.
// The hazard codes are the values the pipeline registers decode.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    HZ_NONE        = 4'd0,
    HZ_STALL_FRONT = 4'd1,
    HZ_STALL_ALL   = 4'd2,
    HZ_FLUSH_ALL   = 4'd3
  } hazard_code_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hazard_state_e;

  localparam int unsigned FLUSH_CNT_W = 3;
  localparam logic [1:0]  WBSEL_LOAD  = 2'b00;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: an ID source register that matches a
// load still in EX cannot be forwarded and needs a one-cycle bubble.
module pipeline_hazard_ctrl_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [1:0] id_uses_reg_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_reg_wen_i,
  input  logic [1:0] ex_reg_wbsel_i,
  output logic       load_use_o
);

  logic exIsLoad;
  logic rs1Hit;
  logic rs2Hit;

  // x0 never carries a real dependency, so a load targeting it is harmless.
  always_comb begin
    exIsLoad   = ex_reg_wen_i && (ex_reg_wbsel_i == WBSEL_LOAD) && (ex_rd_i != 5'd0);
    rs1Hit     = id_uses_reg_i[0] && (id_rs1_i == ex_rd_i);
    rs2Hit     = id_uses_reg_i[1] && (id_rs2_i == ex_rd_i);
    load_use_o = exIsLoad && (rs1Hit || rs2Hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer: arbitrates redirect, data-memory wait and load-use into a
// stage control code. Optional perf counters are enabled by HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [1:0]  id_uses_reg_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_wen_i,
  input  logic [1:0]  ex_reg_wbsel_i,
  input  logic        redirect_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic [3:0]  hazard_signal_o,
  output logic        busy_o,
  output logic        timeout_err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_front_o,
  output logic [31:0] perf_stall_all_o,
  output logic [31:0] perf_flush_o
`endif
);

  localparam int unsigned          WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]      WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hazard_state_e          state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic [WAIT_W-1:0]      waitCnt_q, waitCnt_d;
  logic                   timeoutErr_q, timeoutErr_d;
  logic                   loadUse;
  logic                   memStall;
  hazard_code_e           hazard;

  pipeline_hazard_ctrl_load_use_detect load_use_detect (
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_uses_reg_i  (id_uses_reg_i),
    .ex_rd_i        (ex_rd_i),
    .ex_reg_wen_i   (ex_reg_wen_i),
    .ex_reg_wbsel_i (ex_reg_wbsel_i),
    .load_use_o     (loadUse)
  );

  assign memStall = dmem_req_i && !dmem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      flushCnt_q   <= '0;
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // The redirect cycle itself is the first flush cycle; FLUSH only covers the rest.
  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    waitCnt_d    = waitCnt_q;
    timeoutErr_d = timeoutErr_q;
    case (state_q)
      ST_RUN: begin
        if (memStall) begin
          state_d   = ST_MEM_WAIT;
          waitCnt_d = '0;
        end else if (redirect_i) begin
          flushCnt_d = FLUSH_INIT;
          if (FLUSH_INIT != '0) state_d = ST_FLUSH;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d = ST_RUN;
          if (redirect_i) begin
            flushCnt_d = FLUSH_INIT;
            if (FLUSH_INIT != '0) state_d = ST_FLUSH;
          end
        end else begin
          if (waitCnt_q != WAIT_MAX) waitCnt_d = waitCnt_q + 1'b1;
          if (waitCnt_d == WAIT_MAX) timeoutErr_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flushCnt_q <= FLUSH_CNT_W'(1)) begin
          state_d    = ST_RUN;
          flushCnt_d = '0;
        end else begin
          flushCnt_d = flushCnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    hazard = HZ_NONE;
    if (!rst_i) begin
      case (state_q)
        ST_RUN: begin
          if (memStall)        hazard = HZ_STALL_ALL;
          else if (redirect_i) hazard = HZ_FLUSH_ALL;
          else if (loadUse)    hazard = HZ_STALL_FRONT;
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready_i)   hazard = HZ_STALL_ALL;
          else if (redirect_i) hazard = HZ_FLUSH_ALL;
        end
        ST_FLUSH: hazard = HZ_FLUSH_ALL;
        default:  hazard = HZ_NONE;
      endcase
    end
  end

  assign hazard_signal_o = hazard;
  assign busy_o          = (state_q != ST_RUN);
  assign timeout_err_o   = timeoutErr_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perfStallFront_q;
  logic [31:0] perfStallAll_q;
  logic [31:0] perfFlush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perfStallFront_q <= '0;
      perfStallAll_q   <= '0;
      perfFlush_q      <= '0;
    end else begin
      if (hazard == HZ_STALL_FRONT) perfStallFront_q <= perfStallFront_q + 32'd1;
      if (hazard == HZ_STALL_ALL)   perfStallAll_q   <= perfStallAll_q + 32'd1;
      if (hazard == HZ_FLUSH_ALL)   perfFlush_q      <= perfFlush_q + 32'd1;
    end
  end

  assign perf_stall_front_o = perfStallFront_q;
  assign perf_stall_all_o   = perfStallAll_q;
  assign perf_flush_o       = perfFlush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (3-cycle flush / long timeout
// and 1-cycle flush / 3-cycle timeout) share stimulus and a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] idRs1 = '0;
  logic [4:0] idRs2 = '0;
  logic [1:0] idUsesReg = '0;
  logic [4:0] exRd = '0;
  logic       exRegWen = 1'b0;
  logic [1:0] exRegWbsel = 2'b01;
  logic       redirect = 1'b0;
  logic       dmemReq = 1'b0;
  logic       dmemReady = 1'b0;

  logic [3:0] hazA, hazB;
  logic       busyA, busyB;
  logic       errA, errB;

  int errors = 0;
  int checks = 0;

  int flushCycles[2] = '{3, 1};
  int memTimeout[2]  = '{255, 3};
  int flushLeft[2];
  bit waiting[2];
  int waitCycles[2];
  bit errSticky[2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(255)) dutA (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_uses_reg_i(idUsesReg), .ex_rd_i(exRd), .ex_reg_wen_i(exRegWen),
    .ex_reg_wbsel_i(exRegWbsel), .redirect_i(redirect), .dmem_req_i(dmemReq),
    .dmem_ready_i(dmemReady), .hazard_signal_o(hazA), .busy_o(busyA),
    .timeout_err_o(errA)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(3)) dutB (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_uses_reg_i(idUsesReg), .ex_rd_i(exRd), .ex_reg_wen_i(exRegWen),
    .ex_reg_wbsel_i(exRegWbsel), .redirect_i(redirect), .dmem_req_i(dmemReq),
    .dmem_ready_i(dmemReady), .hazard_signal_o(hazB), .busy_o(busyB),
    .timeout_err_o(errB)
  );

  function automatic bit modelLoadUse();
    bit srcHit;
    srcHit = (idUsesReg[0] && idRs1 == exRd) || (idUsesReg[1] && idRs2 == exRd);
    return exRegWen && exRegWbsel == 2'b00 && exRd != 5'd0 && srcHit;
  endfunction

  // Expected code: pending flush beats everything, a frozen pipeline waits for
  // memory, otherwise the priority is memory stall, redirect, load-use.
  function automatic int modelHazard(int k);
    if (rst) return 0;
    if (flushLeft[k] > 0) return 3;
    if (waiting[k]) return !dmemReady ? 2 : (redirect ? 3 : 0);
    if (dmemReq && !dmemReady) return 2;
    if (redirect) return 3;
    if (modelLoadUse()) return 1;
    return 0;
  endfunction

  // Wait cycles are the stalled cycles after the one in which the stall was first seen.
  task automatic advanceModel();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        flushLeft[k]  = 0;
        waiting[k]    = 1'b0;
        waitCycles[k] = 0;
        errSticky[k]  = 1'b0;
      end else if (flushLeft[k] > 0) begin
        flushLeft[k]--;
      end else if (waiting[k]) begin
        if (dmemReady) begin
          waiting[k] = 1'b0;
          if (redirect) flushLeft[k] = flushCycles[k] - 1;
        end else begin
          if (waitCycles[k] < memTimeout[k]) waitCycles[k]++;
          if (waitCycles[k] >= memTimeout[k]) errSticky[k] = 1'b1;
        end
      end else if (dmemReq && !dmemReady) begin
        waiting[k]    = 1'b1;
        waitCycles[k] = 0;
      end else if (redirect) begin
        flushLeft[k] = flushCycles[k] - 1;
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] observed, input int expected);
    checks++;
    assert (observed === 32'(expected)) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [1:0] uses, input logic [4:0] rd, input logic wen,
                               input logic [1:0] wbsel, input logic redir, input logic req,
                               input logic rdy);
    rst = r; idRs1 = rs1; idRs2 = rs2; idUsesReg = uses; exRd = rd;
    exRegWen = wen; exRegWbsel = wbsel; redirect = redir; dmemReq = req; dmemReady = rdy;
  endtask

  task automatic applyIdle(input logic r);
    applyStimulus(r, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  // Literal arguments of -1 skip that fixed-value check for the cycle.
  task automatic checkOutput(input string tag, input int litHazA, input int litBusyA, input int litErrB);
    checkVal({tag, "/hazA"}, {28'd0, hazA}, modelHazard(0));
    checkVal({tag, "/hazB"}, {28'd0, hazB}, modelHazard(1));
    checkVal({tag, "/busyA"}, {31'd0, busyA}, int'(flushLeft[0] > 0 || waiting[0]));
    checkVal({tag, "/busyB"}, {31'd0, busyB}, int'(flushLeft[1] > 0 || waiting[1]));
    checkVal({tag, "/errA"}, {31'd0, errA}, int'(errSticky[0]));
    checkVal({tag, "/errB"}, {31'd0, errB}, int'(errSticky[1]));
    if (litHazA >= 0) checkVal({tag, "/hazA_fixed"}, {28'd0, hazA}, litHazA);
    if (litBusyA >= 0) checkVal({tag, "/busyA_fixed"}, {31'd0, busyA}, litBusyA);
    if (litErrB >= 0) checkVal({tag, "/errB_fixed"}, {31'd0, errB}, litErrB);
  endtask

  task automatic runCycle(input string tag, input int litHazA, input int litBusyA, input int litErrB);
    @(negedge clk);
    checkOutput(tag, litHazA, litBusyA, litErrB);
    @(posedge clk);
    advanceModel();
    #1;
  endtask

  initial begin
    applyIdle(1'b1);
    repeat (2) @(posedge clk);
    advanceModel();
    #1;
    applyIdle(1'b0);
    runCycle("idle", 0, 0, 0);

    applyStimulus(1'b0, 5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    runCycle("lu_hit", 1, 0, 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    runCycle("lu_x0", 0, 0, -1);
    applyStimulus(1'b0, 5'd5, 5'd0, 2'b00, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    runCycle("lu_unused", 0, 0, -1);
    applyStimulus(1'b0, 5'd0, 5'd9, 2'b10, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    runCycle("lu_rs2", 1, 0, -1);

    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    runCycle("redir_c1", 3, 0, -1);
    applyIdle(1'b0);
    runCycle("redir_c2", 3, 1, -1);
    runCycle("redir_c3", 3, 1, -1);
    runCycle("redir_done", 0, 0, -1);

    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    runCycle("wait_c1", 2, 0, 0);
    runCycle("wait_c2", 2, 1, 0);
    runCycle("wait_c3", 2, 1, 0);
    runCycle("wait_c4", 2, 1, 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);
    runCycle("wait_ready", 0, 1, 1);
    applyIdle(1'b0);
    runCycle("err_sticky1", 0, 0, 1);
    runCycle("err_sticky2", 0, 0, 1);
    applyIdle(1'b1);
    runCycle("err_rst", 0, -1, -1);
    applyIdle(1'b0);
    runCycle("err_cleared", 0, 0, 0);

    applyStimulus(1'b0, 5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    runCycle("redir_lu", 3, 0, -1);
    applyIdle(1'b0);
    runCycle("redir_lu_c2", 3, 1, -1);
    runCycle("redir_lu_c3", 3, 1, -1);
    runCycle("redir_lu_done", 0, 0, -1);

    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
    runCycle("wredir_c1", 2, 0, -1);
    runCycle("wredir_c2", 2, 1, -1);
    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1);
    runCycle("wredir_ready", 3, 1, -1);
    applyIdle(1'b0);
    runCycle("wredir_f2", 3, 1, -1);
    runCycle("wredir_f3", 3, 1, -1);
    runCycle("wredir_done", 0, 0, -1);

    applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    runCycle("rstflush_c1", 3, 0, -1);
    applyIdle(1'b1);
    runCycle("rstflush_c2", 0, -1, -1);
    applyIdle(1'b0);
    runCycle("rstflush_after", 0, 0, 0);
    runCycle("rstflush_after2", 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)));
      runCycle("random", -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
